// File: rtl/step_controller_pkg.sv
// Shared types and default sizes for the single-step / run controller.
package step_controller_pkg;

  localparam int unsigned DEF_PEND_W  = 3;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10,
    ST_FAULT  = 2'b11
  } state_e;

endpackage

// File: rtl/step_timeout.sv
// Watchdog: counts enabled cycles since the last clear and flags when TIMEOUT is reached.
module step_timeout
  import step_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Saturating counter, held at zero whenever the watchdog is disarmed.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (cnt_q != TMO_W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == TMO_W'(TIMEOUT));
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/step_controller.sv
// Generates the CPU clock-enable from step presses / run mode, with a press queue,
// completed-instruction counter and a stuck-CPU watchdog.
module step_controller
  import step_controller_pkg::*;
#(
  parameter int unsigned PEND_W  = DEF_PEND_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              step_pulse,
  input  logic              run_mode,
  input  logic              halt,
  input  logic              instr_done,
  output logic              cpu_en,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  step_count,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cpu_en_q, busy_q, halted_q, fault_q;
  logic                inc_c, take_c, have_req_c, exec_c, expired;

  assign exec_c = (state_q == ST_EXEC);

  step_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (exec_c),
    .clear   (instr_done),
    .expired (expired)
  );

  // Next state, request consumption and instruction counting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inc_c      = 1'b0;
    take_c     = 1'b0;
    have_req_c = (pend_q != '0) || step_pulse;
    case (state_q)
      ST_IDLE: begin
        inc_c = step_pulse && !run_mode;
        if (run_mode) begin
          state_d = ST_EXEC;
        end else if (have_req_c) begin
          state_d = ST_EXEC;
          take_c  = 1'b1;
        end
      end
      ST_EXEC: begin
        inc_c = step_pulse && !run_mode;
        if (instr_done) begin
          cnt_d = cnt_q + 1'b1;
          if (halt) begin
            state_d = ST_HALTED;
          end else if (run_mode) begin
            state_d = ST_EXEC;
          end else if (have_req_c) begin
            take_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Press queue: a press consumed in the same cycle leaves the count untouched.
  always_comb begin
    pend_d = pend_q;
    if (inc_c && !take_c) begin
      if (pend_q != '1) begin
        pend_d = pend_q + 1'b1;
      end
    end else if (take_c && !inc_c) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
      cpu_en_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      cpu_en_q <= (state_d == ST_EXEC);
      busy_q   <= (state_d == ST_EXEC);
      halted_q <= (state_d == ST_HALTED);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign cpu_en     = cpu_en_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign pending    = pend_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed scenarios plus random stimulus, checked every cycle against a behavioural model.
module tb_step_controller;

  localparam int unsigned PW   = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned TO   = 255;
  localparam int          PMAX = (1 << PW) - 1;

  localparam int M_IDLE = 0, M_EXEC = 1, M_HALT = 2, M_FLT = 3;

  logic          clk_in = 1'b0;
  logic          reset, step_pulse, run_mode, halt, instr_done;
  logic          cpu_en, busy, halted, fault;
  logic [PW-1:0] pending;
  logic [CW-1:0] step_count;

  int m_st, m_pend, m_cnt, m_tmo;
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  step_controller #(
    .PEND_W  (PW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .step_pulse (step_pulse),
    .run_mode   (run_mode),
    .halt       (halt),
    .instr_done (instr_done),
    .cpu_en     (cpu_en),
    .pending    (pending),
    .step_count (step_count),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: one clock of the step-controller rules applied to the model variables.
  task automatic model(input bit p, input bit r, input bit h, input bit d, input bit rn);
    bit want, take, inc;
    int nxt;
    if (!rn) begin
      m_st = M_IDLE; m_pend = 0; m_cnt = 0; m_tmo = 0;
      return;
    end
    want = (m_pend > 0) || p;
    take = 0;
    inc  = p && !r && (m_st == M_IDLE || m_st == M_EXEC);
    nxt  = m_st;
    if (m_st == M_IDLE) begin
      if (r) nxt = M_EXEC;
      else if (want) begin nxt = M_EXEC; take = 1; end
      m_tmo = 0;
    end else if (m_st == M_EXEC) begin
      if (d) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_tmo = 0;
        if (h) nxt = M_HALT;
        else if (r) nxt = M_EXEC;
        else if (want) take = 1;
        else nxt = M_IDLE;
      end else if (m_tmo >= TO) begin
        nxt = M_FLT;
      end else begin
        m_tmo++;
      end
      if (nxt != M_EXEC) m_tmo = 0;
    end
    if (inc && !take) m_pend = (m_pend < PMAX) ? m_pend + 1 : PMAX;
    else if (take && !inc) m_pend = m_pend - 1;
    m_st = nxt;
  endtask

  task automatic cyc(input bit p = 0, input bit r = 0, input bit h = 0, input bit d = 0,
                     input bit rn = 1);
    step_pulse = p; run_mode = r; halt = h; instr_done = d; reset = rn;
    @(posedge clk_in);
    model(p, r, h, d, rn);
    #1;
    check("cpu_en", int'(cpu_en), int'(m_st == M_EXEC));
    check("busy", int'(busy), int'(m_st == M_EXEC));
    check("halted", int'(halted), int'(m_st == M_HALT));
    check("fault", int'(fault), int'(m_st == M_FLT));
    check("pending", int'(pending), m_pend);
    check("step_count", int'(step_count), m_cnt);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit run_r;

    // Reset and quiet idle period
    do_reset(3);
    for (int i = 0; i < 20; i++) cyc();
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_count", int'(step_count), 0);

    // Single step with one-cycle latency
    cyc(1);
    check("step_latency", int'(cpu_en), 1);
    check("step_pend_bypass", int'(pending), 0);
    for (int i = 0; i < 3; i++) cyc();
    cyc(0, 0, 0, 1);
    check("step_count1", int'(step_count), 1);
    check("step_cpu_off", int'(cpu_en), 0);
    check("step_idle_busy", int'(busy), 0);

    // Three queued presses: four instructions back to back
    do_reset(1);
    cyc(1);
    for (int i = 0; i < 3; i++) begin cyc(1); cyc(); end
    check("queue3", int'(pending), 3);
    for (int i = 0; i < 4; i++) begin
      cyc(); cyc(); cyc(0, 0, 0, 1);
      if (i < 3) check("queue_cpu_held", int'(cpu_en), 1);
    end
    check("queue_count4", int'(step_count), 4);
    check("queue_empty", int'(pending), 0);
    check("queue_idle", int'(cpu_en), 0);

    // Saturation and simultaneous press/consume
    do_reset(1);
    cyc(1);
    for (int i = 0; i < 9; i++) cyc(1);
    check("pend_sat", int'(pending), PMAX);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    check("pend_drain2", int'(pending), 2);
    cyc(1, 0, 0, 1);
    check("pend_inc_take", int'(pending), 2);
    check("pend_inc_take_run", int'(cpu_en), 1);

    // Free run, then halt
    do_reset(1);
    cyc(0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1); cyc(0, 1, 0, 1);
      check("run_cpu_en", int'(cpu_en), 1);
    end
    check("run_count10", int'(step_count), 10);
    cyc(0, 1, 1, 1);
    check("halt_flag", int'(halted), 1);
    check("halt_cpu_off", int'(cpu_en), 0);
    for (int i = 0; i < 10; i++) cyc(i % 2 == 0, i % 3 == 0, 0, 1);
    check("halt_sticky", int'(halted), 1);
    check("halt_count_frozen", int'(step_count), 11);

    // Halt without instr_done is ignored
    do_reset(1);
    cyc(1);
    cyc(0, 0, 1, 0);
    check("halt_unqualified", int'(halted), 0);
    cyc(0, 0, 0, 1);

    // Watchdog timeout, then single-cycle reset
    do_reset(1);
    cyc(1);
    for (int i = 0; i < int'(TO) + 5; i++) cyc();
    check("tmo_fault", int'(fault), 1);
    check("tmo_cpu_off", int'(cpu_en), 0);
    cyc(1, 0, 0, 1);
    check("fault_count_frozen", int'(step_count), 0);
    cyc(0, 0, 0, 0, 0);
    check("tmo_reset_fault", int'(fault), 0);
    check("tmo_reset_en", int'(cpu_en), 0);

    // Random traffic
    run_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) run_r = ~run_r;
      cyc($urandom_range(0, 3) == 0, run_r, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 119) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Consumes the debounced one-shot step pulse and the run/step mode switch, and produces the clock-enable that gates the 16-bit RISC datapath.
- In step mode, each button press executes exactly one instruction.
- In run mode, the CPU executes freely until it halts.
- Queues presses that arrive mid-instruction, counts completed instructions for the display, and flags a CPU that stops reporting instruction completion.

Parameters:
PEND_W, 3, width of pending-step queue counter (saturates at 2^PEND_W-1)
CNT_W, 16, width of completed-instruction counter (wraps)
TIMEOUT, 255, max cycles in EXEC without instr_done before fault

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
step_pulse  input  1  one-cycle step request from debounce stage
run_mode  input  1  1 = free run, 0 = single step
halt  input  1  CPU halt instruction retired; qualified by instr_done
instr_done  input  1  one-cycle pulse, CPU finished an instruction
cpu_en  output  1  registered clock-enable to CPU datapath
pending  output  PEND_W  queued step requests not yet started
step_count  output  CNT_W  instructions completed since reset
busy  output  1  state == EXEC
halted  output  1  state == HALTED
fault  output  1  state == FAULT (timeout)

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; cpu_en=0, pending=0, step_count=0, fault=0, halted=0.
  - The timeout counter is cleared.
  - Reset overrides everything, including mid-instruction; no instruction is counted.
- All outputs are registered and are direct functions of state or registers.
- States: IDLE, EXEC, HALTED, FAULT.
- Step queue:
  - step_pulse increments pending when run_mode==0 and state is IDLE or EXEC.
  - step_pulse is ignored when run_mode==1 and in HALTED or FAULT.
  - pending saturates at the maximum value; an extra press is dropped.
  - Increment and consume in the same cycle: pending is unchanged.
- IDLE (cpu_en=0):
  - If run_mode==1 -> EXEC.
  - Else if pending!=0 or step_pulse==1 -> EXEC, consuming one request.
  - A bypass applies: a press in IDLE with pending==0 leaves pending at 0, and cpu_en is 1 in the following cycle. Latency from step_pulse to cpu_en is 1 cycle.
- EXEC (cpu_en=1, timeout counter increments each cycle):
  - On instr_done: step_count+1 (wraps at 2^CNT_W) and the timeout counter clears.
  - After that, transitions are evaluated in priority order:
    - halt==1 -> HALTED.
    - Else run_mode==1 -> stay.
    - Else pending!=0 or step_pulse==1 -> stay, consuming one request.
    - Else -> IDLE.
  - cpu_en drops in the cycle after instr_done when leaving EXEC.
  - If the timeout counter reaches TIMEOUT with no instr_done -> FAULT. An instr_done in the same cycle takes priority, so no fault is raised.
  - run_mode 1->0 mid-instruction: the current instruction completes, then normal step rules apply.
  - run_mode 0->1 in IDLE: EXEC next cycle; pending is retained but not consumed until step mode resumes.
- HALTED (cpu_en=0, halted=1): exit only via reset; step_pulse and run_mode are ignored.
- FAULT (cpu_en=0, fault=1): exit only via reset; step_count is frozen.
- halt without instr_done is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, EXEC=2'b01, HALTED=2'b10, FAULT=2'b11.
  - Default widths PEND_W and CNT_W for use by the display/top level.
- One sub-module, step_timeout, implements the TIMEOUT watchdog:
  - Inputs: clk_in, reset, enable (state==EXEC), clear (instr_done).
  - Output: expired.
- The queue counter and FSM stay in step_controller.

Test Plan:
- Reset held low 3 cycles, then released, with run_mode=0 and no pulses -> cpu_en=0, pending=0, step_count=0 for 20 cycles.
- Single step_pulse in IDLE:
  - cpu_en=1 the next cycle.
  - instr_done 4 cycles later -> step_count=1, cpu_en=0 one cycle after instr_done, state IDLE.
- Three pulses during one EXEC instruction:
  - pending=3.
  - Exactly 4 instructions execute back-to-back with cpu_en held high.
  - step_count=4, pending returns to 0.
- PEND_W=3, nine pulses while busy -> pending saturates at 7; step_pulse coinciding with instr_done and pending=2 leaves pending=2.
- run_mode=1:
  - cpu_en=1 continuously; 10 instr_done pulses -> step_count=10.
  - instr_done with halt=1 -> halted=1, cpu_en=0; later pulses and run_mode toggles produce no change.
- EXEC with no instr_done for TIMEOUT cycles -> fault=1, cpu_en=0; reset low for one cycle -> all outputs return to reset values.
